udp_pkt_source: RTL and testbench

- Self-timed UDP payload generator. It acts as the data initiator that feeds the transmit side of eth_udp_mii in place of the receive-loopback FIFO.
- It issues the start pulse and the byte count, then answers the UDP engine's read_data_req with 32-bit payload words in FIFO-read timing.
- It runs in the clk_25m (MII) domain, beside eth_udp_mii, for link bring-up and throughput tests without a PC sender.

---
 rtl/udp_pkt_source.sv | 134 +++++++++++++
 tb/tb_udp_pkt_source.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_pkt_source.sv
// Self-timed UDP payload generator for the transmit side of eth_udp_mii.
// Starts packets periodically or on trig, then answers word requests with FIFO timing.
module udp_pkt_source #(
  parameter int unsigned INTERVAL_CYC  = 25_000_000,
  parameter int unsigned PAYLOAD_BYTES = 64,
  parameter int unsigned TIMEOUT_CYC   = 2_000_000,
  parameter logic [15:0] MAGIC         = 16'hA55A
) (
  input  logic        clk_i,
  input  logic        sys_rst_n,
  input  logic        enable_i,
  input  logic        trig_i,
  input  logic        read_data_req_i,
  input  logic        send_end_i,
  output logic        send_en_o,
  output logic [31:0] send_data_o,
  output logic [15:0] send_data_num_o,
  output logic        busy_o,
  output logic [15:0] pkt_cnt_o,
  output logic        timeout_err_o
);

  localparam int unsigned WORDS = (PAYLOAD_BYTES + 3) / 4;
  localparam logic [15:0] WORDS16 = 16'(WORDS);
  localparam int TMR_W = $clog2(INTERVAL_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(INTERVAL_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [15:0]       idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       seq_q, seq_d;
  logic              err_q, err_d;
  logic              startReq;
  logic              toHit;

  function automatic logic [31:0] wordAt(input logic [15:0] k, input logic [15:0] s);
    if (k == 16'd0)   return {MAGIC, s};
    if (k < WORDS16)  return {s[7:0], 8'h00, k};
    return 32'h0000_0000;
  endfunction

  assign startReq = trig_i || (enable_i && (timer_q == TMR_LAST));
  // The wait window ends after TIMEOUT_CYC cycles counted from the start pulse.
  assign toHit    = ((to_q + 1'b1) == TO_LAST);

  always_ff @(posedge clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (startReq) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (send_end_i || toHit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d   = timer_q;
    to_d      = to_q;
    idx_d     = idx_q;
    data_d    = data_q;
    pkt_cnt_d = pkt_cnt_q;
    seq_d     = seq_q;
    err_d     = err_q;
    send_en_o = 1'b0;
    busy_o    = 1'b1;
    // Reads are served in every state so a late engine never stalls.
    if (read_data_req_i) begin
      data_d = wordAt(idx_q, seq_q);
      if (idx_q < WORDS16) idx_d = idx_q + 16'd1;
    end
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (!enable_i)               timer_d = '0;
        else if (timer_q != TMR_LAST) timer_d = timer_q + 1'b1;
      end
      START: begin
        send_en_o = 1'b1;
        idx_d     = '0;
        to_d      = '0;
      end
      WAIT: begin
        to_d = to_q + 1'b1;
        if (send_end_i) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          seq_d     = seq_q + 16'd1;
          timer_d   = '0;
        end else if (toHit) begin
          err_d   = 1'b1;
          timer_d = '0;
        end
      end
      default: busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_q   <= '0;
      to_q      <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      pkt_cnt_q <= '0;
      seq_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      to_q      <= to_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      pkt_cnt_q <= pkt_cnt_d;
      seq_q     <= seq_d;
      err_q     <= err_d;
    end
  end

  assign send_data_o     = data_q;
  assign send_data_num_o = 16'(PAYLOAD_BYTES);
  assign pkt_cnt_o       = pkt_cnt_q;
  assign timeout_err_o   = err_q;

endmodule

// File: tb/tb_udp_pkt_source.sv
// Directed bench for udp_pkt_source with a small scoreboard for payload words.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_udp_pkt_source;

  logic        clk = 1'b0;
  logic        sysRstN;
  logic        enable;
  logic        trig;
  logic        readReq;
  logic        sendEnd;
  logic        sendEn;
  logic [31:0] sendData;
  logic [15:0] sendDataNum;
  logic        busy;
  logic [15:0] pktCnt;
  logic        timeoutErr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] expQ[$];
  logic [15:0] modelSeq;
  logic [15:0] modelPkt;
  int          modelIdx;

  always #5 clk = ~clk;

  udp_pkt_source #(
    .INTERVAL_CYC (10),
    .PAYLOAD_BYTES(10),
    .TIMEOUT_CYC  (50),
    .MAGIC        (16'hA55A)
  ) dut (
    .clk_i          (clk),
    .sys_rst_n      (sysRstN),
    .enable_i       (enable),
    .trig_i         (trig),
    .read_data_req_i(readReq),
    .send_end_i     (sendEnd),
    .send_en_o      (sendEn),
    .send_data_o    (sendData),
    .send_data_num_o(sendDataNum),
    .busy_o         (busy),
    .pkt_cnt_o      (pktCnt),
    .timeout_err_o  (timeoutErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Pulse trig and/or send_end for one cycle, ending on the next falling edge.
  task automatic applyStimulus(input bit doTrig, input bit doEnd);
    trig    = doTrig;
    sendEnd = doEnd;
    step();
    trig    = 1'b0;
    sendEnd = 1'b0;
  endtask

  task automatic waitSendEn(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (sendEn) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Payload has 3 words (10 bytes); beyond that the source pads with zero.
  function automatic logic [31:0] expWord(input logic [15:0] s, input int k);
    logic [23:0] k24;
    k24 = 24'(k);
    if (k == 0) return {16'hA55A, s};
    if (k < 3)  return {s[7:0], k24};
    return 32'h0;
  endfunction

  task automatic readWords(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      expQ.push_back(expWord(modelSeq, modelIdx));
      if (modelIdx < 3) modelIdx++;
      readReq = 1'b1;
      step();
      checkOutput(tag, sendData, expQ.pop_front());
      checkOutput("data_num", {16'h0, sendDataNum}, 32'd10);
    end
    readReq = 1'b0;
  endtask

  task automatic startByTrig();
    applyStimulus(1'b1, 1'b0);
    checkOutput("trig_send_en", {31'h0, sendEn}, 32'd1);
    modelIdx = 0;
    step();
  endtask

  task automatic finishPacket(input string tag);
    applyStimulus(1'b0, 1'b1);
    modelPkt++;
    modelSeq++;
    checkOutput(tag, {16'h0, pktCnt}, {16'h0, modelPkt});
    checkOutput("busy_after_end", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    logic [31:0] lastData;
    sysRstN  = 1'b0;
    enable   = 1'b1;
    trig     = 1'b0;
    readReq  = 1'b0;
    sendEnd  = 1'b0;
    modelSeq = 16'h0;
    modelPkt = 16'h0;
    modelIdx = 0;
    repeat (3) step();

    checkOutput("rst_send_en", {31'h0, sendEn}, 32'd0);
    checkOutput("rst_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst_send_data", sendData, 32'h0);
    checkOutput("rst_pkt_cnt", {16'h0, pktCnt}, 32'h0);
    checkOutput("rst_timeout_err", {31'h0, timeoutErr}, 32'd0);
    checkOutput("rst_data_num", {16'h0, sendDataNum}, 32'd10);

    // Periodic sending: three packets, each ended 20 cycles after its start.
    sysRstN = 1'b1;
    waitSendEn(30, c);
    checkOutput("first_start_delay", c, 32'd10);
    checkOutput("busy_at_start", {31'h0, busy}, 32'd1);
    for (int p = 1; p <= 3; p++) begin
      repeat (20) step();
      finishPacket("pkt_cnt_periodic");
      if (p < 3) begin
        waitSendEn(30, c);
        checkOutput("interval_delay", c, 32'd10);
        if (p == 2) enable = 1'b0;
      end
    end
    waitSendEn(25, c);
    checkOutput("no_auto_start_disabled", c, 32'hFFFF_FFFF);

    // Manual trig with a second trig while busy.
    applyStimulus(1'b1, 1'b0);
    checkOutput("trig_send_en", {31'h0, sendEn}, 32'd1);
    checkOutput("trig_busy", {31'h0, busy}, 32'd1);
    modelIdx = 0;
    step();
    applyStimulus(1'b1, 1'b0);
    checkOutput("retrig_no_send_en", {31'h0, sendEn}, 32'd0);
    waitSendEn(10, c);
    checkOutput("retrig_ignored", c, 32'hFFFF_FFFF);
    checkOutput("busy_while_waiting", {31'h0, busy}, 32'd1);
    finishPacket("pkt_cnt_trig");

    // Back-to-back packet at the minimum gap.
    startByTrig();
    finishPacket("pkt_cnt_min_gap");

    // Payload read in IDLE with seq=5.
    readWords(4, "word_seq5");
    lastData = 32'h0;
    step();
    checkOutput("data_hold", sendData, lastData);

    applyStimulus(1'b0, 1'b1);
    checkOutput("send_end_idle_ignored", {16'h0, pktCnt}, {16'h0, modelPkt});

    // send_end on the timeout terminal cycle wins.
    applyStimulus(1'b1, 1'b0);
    modelIdx = 0;
    repeat (49) step();
    checkOutput("busy_before_terminal", {31'h0, busy}, 32'd1);
    finishPacket("pkt_cnt_end_at_terminal");
    checkOutput("no_err_when_end_wins", {31'h0, timeoutErr}, 32'd0);

    // Timeout without send_end.
    applyStimulus(1'b1, 1'b0);
    modelIdx = 0;
    c = -1;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (!busy) begin
        c = i;
        break;
      end
    end
    checkOutput("timeout_busy_drop", c, 32'd50);
    checkOutput("timeout_err_set", {31'h0, timeoutErr}, 32'd1);
    checkOutput("timeout_pkt_cnt", {16'h0, pktCnt}, {16'h0, modelPkt});
    startByTrig();
    readWords(1, "word0_after_timeout");
    finishPacket("pkt_cnt_after_timeout");
    checkOutput("timeout_err_sticky", {31'h0, timeoutErr}, 32'd1);

    // Reset in the middle of a packet after two words.
    startByTrig();
    readWords(2, "word_before_reset");
    #2 sysRstN = 1'b0;
    #1;
    checkOutput("midrst_send_en", {31'h0, sendEn}, 32'd0);
    checkOutput("midrst_busy", {31'h0, busy}, 32'd0);
    checkOutput("midrst_send_data", sendData, 32'h0);
    checkOutput("midrst_pkt_cnt", {16'h0, pktCnt}, 32'h0);
    checkOutput("midrst_timeout_err", {31'h0, timeoutErr}, 32'd0);
    step();
    sysRstN  = 1'b1;
    modelSeq = 16'h0;
    modelPkt = 16'h0;
    modelIdx = 0;
    startByTrig();
    readWords(1, "word0_after_reset");
    finishPacket("pkt_cnt_after_reset");

    // Counter wrap from 16'hFFFF.
    force dut.pkt_cnt_q = 16'hFFFF;
    force dut.seq_q     = 16'hFFFF;
    step();
    release dut.pkt_cnt_q;
    release dut.seq_q;
    step();
    modelSeq = 16'hFFFF;
    modelPkt = 16'hFFFF;
    checkOutput("pkt_cnt_preset", {16'h0, pktCnt}, 32'h0000_FFFF);
    startByTrig();
    readWords(1, "word0_seq_ffff");
    finishPacket("pkt_cnt_wrap");
    startByTrig();
    readWords(1, "word0_seq_wrapped");
    finishPacket("pkt_cnt_after_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
